// File: rtl/regfile_pkg.sv
// Shared types and constants for the register-file writeback arbiter.
package regfile_pkg;

  localparam int DEF_DATA_W = 64;
  localparam int DEF_ADDR_W = 5;

  // X31 is hard-wired to zero: it is never written and never marked pending.
  localparam logic [4:0] ZERO_REG = 5'd31;

  // One buffered multi-cycle result waiting for the write port.
  typedef struct packed {
    logic [DEF_ADDR_W-1:0] addr;
    logic [DEF_DATA_W-1:0] data;
  } wb_req_t;

  // WAIT holds a non-empty buffer; DRAIN is the single forced-write cycle.
  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    DRAIN
  } arb_state_t;

endpackage

// File: rtl/wb_fifo.sv
// Synchronous FIFO for buffered writeback results, with full/empty flags,
// an occupancy count and an asynchronous active-low clear.
module wb_fifo
  import regfile_pkg::*;
#(
  parameter int  DEPTH = 4,
  parameter type T     = wb_req_t
) (
  input  logic                   clk,
  input  logic                   clr_n,
  input  logic                   push,
  input  T                       push_data,
  input  logic                   pop,
  output T                       head,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] level
);

  localparam int PTR_W = $clog2(DEPTH);

  T                 mem [DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W:0]   count;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == (PTR_W + 1)'(DEPTH));
  assign empty   = (count == '0);
  assign level   = count;
  assign head    = mem[rd_ptr];
  assign do_pop  = pop && !empty;
  // A full FIFO can still take a push when the head leaves in the same cycle.
  assign do_push = push && (!full || do_pop);

  // Pointer and occupancy bookkeeping; DEPTH is a power of two so pointers wrap naturally.
  always_ff @(posedge clk or negedge clr_n) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (!clr_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Entry storage.
  always_ff @(posedge clk) begin
    // NOTE: the data array is not reset; the cleared count makes stale entries unreachable.
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Arbitrates the single register-file write port between the pipeline
// writeback stage and buffered multi-cycle results, keeps the pending
// scoreboard for the hazard unit and forces a drain when results starve.
module regfile_wb_arbiter
  import regfile_pkg::*;
#(
  parameter int DATA_W     = DEF_DATA_W,
  parameter int ADDR_W     = DEF_ADDR_W,
  parameter int FIFO_DEPTH = 4,
  parameter int STARVE_MAX = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              pipe_wr_en,
  input  logic [ADDR_W-1:0] pipe_wr_addr,
  input  logic [DATA_W-1:0] pipe_wr_data,
  output logic              pipe_stall,
  input  logic              issue_en,
  input  logic [ADDR_W-1:0] issue_addr,
  input  logic              mul_valid,
  output logic              mul_ready,
  input  logic [ADDR_W-1:0] mul_addr,
  input  logic [DATA_W-1:0] mul_data,
  output logic              RegWrite,
  output logic [ADDR_W-1:0] WriteRegister,
  output logic [DATA_W-1:0] WriteData,
  output logic [31:0]       pending,
  output logic              sb_err
);

  localparam int                CNT_W       = $clog2(STARVE_MAX + 1);
  localparam int                LVL_W       = $clog2(FIFO_DEPTH) + 1;
  localparam logic [ADDR_W-1:0] ZERO_ADDR   = ADDR_W'(ZERO_REG);
  localparam logic [CNT_W-1:0]  STARVE_LAST = CNT_W'(STARVE_MAX - 1);

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } req_t;

  arb_state_t       state;
  arb_state_t       state_next;
  logic [CNT_W-1:0] starve_cnt;
  logic [CNT_W-1:0] starve_cnt_next;

  req_t             fifo_head;
  logic             fifo_full;
  logic             fifo_empty;
  logic [LVL_W-1:0] fifo_level;
  logic             fifo_push;
  logic             fifo_pop;
  logic             fifo_goes_empty;
  logic             pipe_sel;

  logic [31:0]      set_mask;
  logic [31:0]      clr_mask;
  logic             err_now;

  // Results to X31 complete the handshake but are dropped before the buffer.
  assign mul_ready       = !fifo_full;
  assign fifo_push       = mul_valid && mul_ready && (mul_addr != ZERO_ADDR);
  assign fifo_goes_empty = fifo_pop && !fifo_push && (fifo_level == LVL_W'(1));

  wb_fifo #(
    .DEPTH (FIFO_DEPTH),
    .T     (req_t)
  ) u_fifo (
    .clk       (clk),
    .clr_n     (reset),
    .push      (fifo_push),
    .push_data ('{addr: mul_addr, data: mul_data}),
    .pop       (fifo_pop),
    .head      (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .level     (fifo_level)
  );

  // Write-port mux: pipeline first unless stalled, then the buffer head.
  always_comb begin
    // NOTE: every output gets a default first so no path can infer a latch.
    RegWrite      = 1'b0;
    WriteRegister = '0;
    WriteData     = '0;
    fifo_pop      = 1'b0;
    pipe_sel      = 1'b0;
    if (!pipe_stall && pipe_wr_en) begin
      pipe_sel      = 1'b1;
      RegWrite      = 1'b1;
      WriteRegister = pipe_wr_addr;
      WriteData     = pipe_wr_data;
    end else if (!fifo_empty) begin
      fifo_pop      = 1'b1;
      RegWrite      = 1'b1;
      WriteRegister = fifo_head.addr;
      WriteData     = fifo_head.data;
    end
  end

  // Starvation FSM: count blocked cycles, force one drain write at the limit.
  always_comb begin
    state_next      = state;
    starve_cnt_next = starve_cnt;
    case (state)
      IDLE: begin
        starve_cnt_next = '0;
        if (fifo_push) state_next = WAIT;
      end
      WAIT: begin
        if (fifo_pop) begin
          starve_cnt_next = '0;
          if (fifo_goes_empty) state_next = IDLE;
        end else if (pipe_wr_en) begin
          if (starve_cnt == STARVE_LAST) begin
            starve_cnt_next = CNT_W'(STARVE_MAX);
            state_next      = DRAIN;
          end else begin
            starve_cnt_next = starve_cnt + 1'b1;
          end
        end
      end
      DRAIN: begin
        starve_cnt_next = '0;
        state_next      = fifo_goes_empty ? IDLE : WAIT;
      end
      default: begin
        starve_cnt_next = '0;
        state_next      = IDLE;
      end
    endcase
  end

  // FSM state, starve counter and the registered stall toward the pipeline.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      starve_cnt <= '0;
      pipe_stall <= 1'b0;
    end else begin
      state      <= state_next;
      starve_cnt <= starve_cnt_next;
      pipe_stall <= (state_next == DRAIN);
    end
  end

  // Scoreboard set/clear masks and protocol-violation detection.
  always_comb begin
    set_mask = '0;
    clr_mask = '0;
    if (issue_en && (issue_addr != ZERO_ADDR)) set_mask[issue_addr] = 1'b1;
    if (fifo_pop) clr_mask[fifo_head.addr] = 1'b1;
    err_now = (issue_en && pending[issue_addr]) || (pipe_sel && pending[pipe_wr_addr]);
  end

  // Pending scoreboard (set beats clear on the same address) and sticky error.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pending <= '0;
      sb_err  <= 1'b0;
    end else begin
      pending <= (pending & ~clr_mask) | set_mask;
      if (err_now) sb_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Self-checking bench for regfile_wb_arbiter: directed scenarios with
// hand-derived expectations, then randomized traffic against a queue model.
module tb_regfile_wb_arbiter;

  localparam int DW     = 64;
  localparam int AW     = 5;
  localparam int DEPTH  = 4;
  localparam int STARVE = 3;

  logic          clk = 1'b0;
  logic          reset;
  logic          pipe_wr_en;
  logic [AW-1:0] pipe_wr_addr;
  logic [DW-1:0] pipe_wr_data;
  logic          pipe_stall;
  logic          issue_en;
  logic [AW-1:0] issue_addr;
  logic          mul_valid;
  logic          mul_ready;
  logic [AW-1:0] mul_addr;
  logic [DW-1:0] mul_data;
  logic          RegWrite;
  logic [AW-1:0] WriteRegister;
  logic [DW-1:0] WriteData;
  logic [31:0]   pending;
  logic          sb_err;

  int n_tests = 0;
  int n_fail  = 0;

  wire [AW+DW:0] port_now = {RegWrite, WriteRegister, WriteData};

  regfile_wb_arbiter #(
    .DATA_W     (DW),
    .ADDR_W     (AW),
    .FIFO_DEPTH (DEPTH),
    .STARVE_MAX (STARVE)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .pipe_wr_en    (pipe_wr_en),
    .pipe_wr_addr  (pipe_wr_addr),
    .pipe_wr_data  (pipe_wr_data),
    .pipe_stall    (pipe_stall),
    .issue_en      (issue_en),
    .issue_addr    (issue_addr),
    .mul_valid     (mul_valid),
    .mul_ready     (mul_ready),
    .mul_addr      (mul_addr),
    .mul_data      (mul_data),
    .RegWrite      (RegWrite),
    .WriteRegister (WriteRegister),
    .WriteData     (WriteData),
    .pending       (pending),
    .sb_err        (sb_err)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  // Expected write-port tuple {RegWrite, WriteRegister, WriteData}.
  function automatic logic [AW+DW:0] pw(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
    return {we, a, d};
  endfunction

  task automatic drive_idle();
    pipe_wr_en = 0; pipe_wr_addr = '0; pipe_wr_data = '0;
    issue_en = 0; issue_addr = '0;
    mul_valid = 0; mul_addr = '0; mul_data = '0;
  endtask

  task automatic next();
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    drive_idle();
    reset = 0;
    next(); next();
    reset = 1;
  endtask

  task automatic test_reset();
    drive_idle();
    reset = 0;
    next();
    @(negedge clk);
    n_tests++; if (port_now !== pw(0, 0, 0)) begin n_fail++; $display("FAIL reset_port: got %h want %h", port_now, pw(0, 0, 0)); end
    n_tests++; if (pending !== 32'h0) begin n_fail++; $display("FAIL reset_pending: got %h want 0", pending); end
    n_tests++; if ({pipe_stall, sb_err, mul_ready} !== 3'b001) begin n_fail++; $display("FAIL reset_flags: got stall/err/ready %b want 001", {pipe_stall, sb_err, mul_ready}); end
    next();
    reset = 1;
  endtask

  task automatic test_basic();
    do_reset();
    issue_en = 1; issue_addr = 5;
    next();
    issue_en = 0; mul_valid = 1; mul_addr = 5; mul_data = 64'hAA;
    @(negedge clk);
    n_tests++; if (port_now !== pw(0, 0, 0)) begin n_fail++; $display("FAIL basic_no_bypass: got %h want %h", port_now, pw(0, 0, 0)); end
    n_tests++; if (pending !== 32'h20) begin n_fail++; $display("FAIL basic_pending_set: got %h want 20", pending); end
    next();
    mul_valid = 0;
    @(negedge clk);
    n_tests++; if (port_now !== pw(1, 5, 64'hAA)) begin n_fail++; $display("FAIL basic_write: got %h want %h", port_now, pw(1, 5, 64'hAA)); end
    next();
    @(negedge clk);
    n_tests++; if (port_now !== pw(0, 0, 0)) begin n_fail++; $display("FAIL basic_after: got %h want %h", port_now, pw(0, 0, 0)); end
    n_tests++; if ({pending, sb_err} !== 33'h0) begin n_fail++; $display("FAIL basic_pending_clr: got %h err %b want 0", pending, sb_err); end
  endtask

  task automatic test_priority();
    do_reset();
    issue_en = 1; issue_addr = 7;
    next();
    issue_en = 0;
    pipe_wr_en = 1; pipe_wr_addr = 3; pipe_wr_data = 64'h11;
    mul_valid = 1; mul_addr = 7; mul_data = 64'h22;
    @(negedge clk);
    n_tests++; if (port_now !== pw(1, 3, 64'h11)) begin n_fail++; $display("FAIL prio_pipe_first: got %h want %h", port_now, pw(1, 3, 64'h11)); end
    n_tests++; if (pending !== 32'h80) begin n_fail++; $display("FAIL prio_pending_set: got %h want 80", pending); end
    next();
    drive_idle();
    @(negedge clk);
    n_tests++; if (port_now !== pw(1, 7, 64'h22)) begin n_fail++; $display("FAIL prio_mul_second: got %h want %h", port_now, pw(1, 7, 64'h22)); end
    next();
    @(negedge clk);
    n_tests++; if ({RegWrite, pending} !== 33'h0) begin n_fail++; $display("FAIL prio_clear: got we %b pending %h want 0", RegWrite, pending); end
  endtask

  task automatic test_starve_drain();
    do_reset();
    mul_valid = 1; mul_addr = 9; mul_data = 64'h99;
    pipe_wr_en = 1; pipe_wr_addr = 1; pipe_wr_data = 64'h100;
    next();
    mul_valid = 0;
    for (int i = 0; i < STARVE; i++) begin
      pipe_wr_data = 64'h101 + 64'(i);
      @(negedge clk);
      n_tests++; if ({pipe_stall, port_now} !== {1'b0, pw(1, 1, pipe_wr_data)}) begin n_fail++; $display("FAIL starve_blocked_%0d: got stall %b port %h want stall 0 port %h", i, pipe_stall, port_now, pw(1, 1, pipe_wr_data)); end
      next();
    end
    @(negedge clk);
    n_tests++; if ({pipe_stall, port_now} !== {1'b1, pw(1, 9, 64'h99)}) begin n_fail++; $display("FAIL starve_drain: got stall %b port %h want stall 1 port %h", pipe_stall, port_now, pw(1, 9, 64'h99)); end
    next();
    @(negedge clk);
    n_tests++; if ({pipe_stall, port_now} !== {1'b0, pw(1, 1, pipe_wr_data)}) begin n_fail++; $display("FAIL starve_release: got stall %b port %h want stall 0 port %h", pipe_stall, port_now, pw(1, 1, pipe_wr_data)); end
    next();
    drive_idle();
  endtask

  task automatic test_full();
    do_reset();
    pipe_wr_en = 1; pipe_wr_addr = 2; pipe_wr_data = 64'h200;
    for (int i = 0; i < DEPTH; i++) begin
      mul_valid = 1; mul_addr = 5'(10 + i); mul_data = 64'hA0 + 64'(i);
      @(negedge clk);
      n_tests++; if (mul_ready !== 1'b1) begin n_fail++; $display("FAIL full_ready_%0d: got %b want 1", i, mul_ready); end
      next();
    end
    mul_addr = 14; mul_data = 64'hA4;
    @(negedge clk);
    n_tests++; if ({mul_ready, pipe_stall, port_now} !== {2'b01, pw(1, 10, 64'hA0)}) begin n_fail++; $display("FAIL full_drain: got ready %b stall %b port %h want 0 1 %h", mul_ready, pipe_stall, port_now, pw(1, 10, 64'hA0)); end
    next();
    @(negedge clk);
    n_tests++; if ({mul_ready, pipe_stall, port_now} !== {2'b10, pw(1, 2, 64'h200)}) begin n_fail++; $display("FAIL full_accept5: got ready %b stall %b port %h want 1 0 %h", mul_ready, pipe_stall, port_now, pw(1, 2, 64'h200)); end
    next();
    drive_idle();
    @(negedge clk);
    n_tests++; if (mul_ready !== 1'b0) begin n_fail++; $display("FAIL full_refilled: got %b want 0", mul_ready); end
    for (int j = 0; j < DEPTH; j++) begin
      if (j > 0) @(negedge clk);
      n_tests++; if (port_now !== pw(1, 5'(11 + j), 64'hA1 + 64'(j))) begin n_fail++; $display("FAIL full_order_%0d: got %h want %h", j, port_now, pw(1, 5'(11 + j), 64'hA1 + 64'(j))); end
      next();
    end
    @(negedge clk);
    n_tests++; if ({mul_ready, port_now} !== {1'b1, pw(0, 0, 0)}) begin n_fail++; $display("FAIL full_empty: got ready %b port %h want 1 %h", mul_ready, port_now, pw(0, 0, 0)); end
  endtask

  task automatic test_zero_reg();
    do_reset();
    mul_valid = 1; mul_addr = 31; mul_data = 64'h55;
    @(negedge clk);
    n_tests++; if (mul_ready !== 1'b1) begin n_fail++; $display("FAIL zero_ready: got %b want 1", mul_ready); end
    next();
    mul_valid = 0;
    @(negedge clk);
    n_tests++; if (RegWrite !== 1'b0) begin n_fail++; $display("FAIL zero_no_write: got %b want 0", RegWrite); end
    next();
    issue_en = 1; issue_addr = 31;
    next(); next();
    issue_en = 0;
    @(negedge clk);
    n_tests++; if ({pending, sb_err} !== 33'h0) begin n_fail++; $display("FAIL zero_issue: got pending %h err %b want 0", pending, sb_err); end
  endtask

  task automatic test_sb_err_and_reset();
    do_reset();
    issue_en = 1; issue_addr = 4;
    next();
    @(negedge clk);
    n_tests++; if ({pending, sb_err} !== {32'h10, 1'b0}) begin n_fail++; $display("FAIL err_before: got pending %h err %b want 10 0", pending, sb_err); end
    next();
    issue_en = 0;
    repeat (3) next();
    @(negedge clk);
    n_tests++; if (sb_err !== 1'b1) begin n_fail++; $display("FAIL err_double_issue_sticky: got %b want 1", sb_err); end
    do_reset();
    issue_en = 1; issue_addr = 6;
    next();
    issue_en = 0; pipe_wr_en = 1; pipe_wr_addr = 6; pipe_wr_data = 64'h1;
    @(negedge clk);
    n_tests++; if (port_now !== pw(1, 6, 64'h1)) begin n_fail++; $display("FAIL err_pipe_write_proceeds: got %h want %h", port_now, pw(1, 6, 64'h1)); end
    next();
    drive_idle();
    @(negedge clk);
    n_tests++; if (sb_err !== 1'b1) begin n_fail++; $display("FAIL err_pipe_pending: got %b want 1", sb_err); end
    // Two results stay buffered behind pipeline traffic, then reset drops them.
    do_reset();
    pipe_wr_en = 1; pipe_wr_addr = 1; pipe_wr_data = 64'h7;
    issue_en = 1; issue_addr = 20;
    mul_valid = 1; mul_addr = 20; mul_data = 64'h20;
    next();
    issue_en = 0; mul_addr = 21; mul_data = 64'h21;
    next();
    drive_idle();
    reset = 0;
    #1;
    n_tests++; if ({port_now, pending, pipe_stall, sb_err, mul_ready} !== {pw(0, 0, 0), 32'h0, 3'b001}) begin n_fail++; $display("FAIL mid_reset_outputs: got port %h pending %h stall/err/ready %b", port_now, pending, {pipe_stall, sb_err, mul_ready}); end
    next();
    reset = 1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      n_tests++; if (RegWrite !== 1'b0) begin n_fail++; $display("FAIL mid_reset_no_write_%0d: got %b want 0", i, RegWrite); end
      next();
    end
  endtask

  // Reference model: in-order queue of results, pending bit array, sticky
  // error, and a count of consecutive cycles the oldest result lost to the pipe.
  typedef struct {
    logic [AW-1:0] a;
    logic [DW-1:0] d;
  } ent_t;

  task automatic test_random();
    ent_t          mq[$];
    logic [31:0]   m_pend = '0;
    bit            m_err = 0;
    bit            m_stall = 0;
    int            m_cnt = 0;
    bit            p_sel;
    bit            f_sel;
    bit            accept;
    logic [AW+DW:0] exp_port;
    do_reset();
    for (int i = 0; i < 600; i++) begin
      pipe_wr_en   = ($urandom_range(3) != 0);
      pipe_wr_addr = AW'($urandom_range(31));
      pipe_wr_data = {$urandom, $urandom};
      issue_en     = ($urandom_range(7) == 0);
      issue_addr   = AW'($urandom_range(31));
      mul_valid    = ($urandom_range(1) == 1);
      mul_addr     = AW'($urandom_range(31));
      mul_data     = {$urandom, $urandom};
      @(negedge clk);
      p_sel = !m_stall && pipe_wr_en;
      f_sel = !p_sel && (mq.size() > 0);
      exp_port = p_sel ? pw(1, pipe_wr_addr, pipe_wr_data) :
                 f_sel ? pw(1, mq[0].a, mq[0].d) : pw(0, 0, 0);
      n_tests++; if (port_now !== exp_port) begin n_fail++; $display("FAIL rand_port[%0d]: got %h want %h", i, port_now, exp_port); end
      n_tests++; if ({mul_ready, pipe_stall, sb_err} !== {mq.size() < DEPTH, m_stall, m_err}) begin n_fail++; $display("FAIL rand_flags[%0d]: got ready/stall/err %b want %b", i, {mul_ready, pipe_stall, sb_err}, {mq.size() < DEPTH, m_stall, m_err}); end
      n_tests++; if (pending !== m_pend) begin n_fail++; $display("FAIL rand_pending[%0d]: got %h want %h", i, pending, m_pend); end
      @(posedge clk);
      accept = mul_valid && (mq.size() < DEPTH);
      if ((issue_en && issue_addr != 31 && m_pend[issue_addr]) || (p_sel && m_pend[pipe_wr_addr])) m_err = 1;
      if (m_stall) begin
        m_stall = 0;
        m_cnt   = 0;
      end else if (p_sel && mq.size() > 0) begin
        m_cnt++;
        if (m_cnt == STARVE) m_stall = 1;
      end else if (f_sel) begin
        m_cnt = 0;
      end
      if (f_sel) begin
        m_pend[mq[0].a] = 1'b0;
        void'(mq.pop_front());
      end
      if (issue_en && issue_addr != 31) m_pend[issue_addr] = 1'b1;
      if (accept && mul_addr != 31) mq.push_back('{a: mul_addr, d: mul_data});
      #1;
    end
    drive_idle();
  endtask

  initial begin
    drive_idle();
    reset = 0;
    test_reset();
    test_basic();
    test_priority();
    test_starve_drain();
    test_full();
    test_zero_reg();
    test_sb_err_and_reset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
